// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared pipeline types for the RV32 hazard/forwarding controller.
// Forward-select encoding, register index and ID/EX tag bundle.
package riscv_pipe_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     reg_write;
    logic     mem_read;
  } idex_tag_t;

  // Nearest producer wins; x0 is never a forwarding source.
  function automatic fwd_sel_t fwd_pick(
    input reg_idx_t src,
    input logic     em_rw,
    input reg_idx_t em_rd,
    input logic     mw_rw,
    input reg_idx_t mw_rd
  );
    if (em_rw && em_rd != '0 && em_rd == src)
      return FWD_EXMEM;
    else if (mw_rw && mw_rd != '0 && mw_rd == src)
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Hazard controller bus: ID-stage tags in, pipeline controls out.
// The controller sits on the slave side.
interface hazard_forward_ctrl_if #(
  parameter int CNT_W = 16
);
  import riscv_pipe_pkg::*;

  reg_idx_t       id_rs1;
  reg_idx_t       id_rs2;
  reg_idx_t       id_rd;
  logic           id_uses_rs1;
  logic           id_uses_rs2;
  logic           id_reg_write;
  logic           id_mem_read;
  logic           ex_branch_taken;
  logic           pc_write;
  logic           if_id_write;
  logic           if_id_flush;
  logic           id_ex_bubble;
  fwd_sel_t       forward_a;
  fwd_sel_t       forward_b;
  logic           wb_bypass_rs1;
  logic           wb_bypass_rs2;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_rd,
    output id_uses_rs1, id_uses_rs2,
    output id_reg_write, id_mem_read,
    output ex_branch_taken,
    input  pc_write, if_id_write,
    input  if_id_flush, id_ex_bubble,
    input  forward_a, forward_b,
    input  wb_bypass_rs1, wb_bypass_rs2,
    input  stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_rd,
    input  id_uses_rs1, id_uses_rs2,
    input  id_reg_write, id_mem_read,
    input  ex_branch_taken,
    output pc_write, if_id_write,
    output if_id_flush, id_ex_bubble,
    output forward_a, forward_b,
    output wb_bypass_rs1, wb_bypass_rs2,
    output stall_count, flush_count
  );

endinterface

// File: rtl/hazard_forward_ctrl_sat_counter.sv
// Saturating event counter for debug statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stop at all-ones, clear synchronously.
  always_ff @(posedge clk) begin
    if (clear)
      count <= '0;
    else if (inc && count != '1)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// 5-stage RV32 hazard controller: load-use stall, branch flush,
// EX forwarding selects, ID write-back bypass, debug counters.
module hazard_forward_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  reset,
  hazard_forward_ctrl_if.slave bus
);

  idex_tag_t idex;
  reg_idx_t  exmem_rd;
  logic      exmem_rw;
  logic      exmem_mr;
  reg_idx_t  memwb_rd;
  logic      memwb_rw;

  logic     load_use;
  logic     sel_rst;
  logic     sel_br;
  logic     sel_lu;
  logic     pc_write;
  logic     if_id_write;
  logic     if_id_flush;
  logic     id_ex_bubble;
  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;
  logic     byp_rs1;
  logic     byp_rs2;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // EX/MEM load flag is tracked for completeness only.
  logic unused_exmem_mr;
  assign unused_exmem_mr = exmem_mr;

  assign load_use = idex.mem_read
    && idex.rd != '0
    && ((bus.id_uses_rs1 && bus.id_rs1 == idex.rd)
     || (bus.id_uses_rs2 && bus.id_rs2 == idex.rd));

  assign sel_rst = reset;
  assign sel_br  = !reset && bus.ex_branch_taken;
  assign sel_lu  = !reset && !bus.ex_branch_taken
                && load_use;

  // Pipeline control: reset, then branch, then load-use.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    unique case (1'b1)
      sel_rst: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      sel_br: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      sel_lu: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Forward selects and WB bypass, all quiet during reset.
  always_comb begin
    fwd_a   = FWD_RF;
    fwd_b   = FWD_RF;
    byp_rs1 = 1'b0;
    byp_rs2 = 1'b0;
    if (!reset) begin
      fwd_a = fwd_pick(idex.rs1, exmem_rw, exmem_rd,
                       memwb_rw, memwb_rd);
      fwd_b = fwd_pick(idex.rs2, exmem_rw, exmem_rd,
                       memwb_rw, memwb_rd);
      byp_rs1 = memwb_rw && memwb_rd != '0
             && bus.id_uses_rs1
             && bus.id_rs1 == memwb_rd;
      byp_rs2 = memwb_rw && memwb_rd != '0
             && bus.id_uses_rs2
             && bus.id_rs2 == memwb_rd;
    end
  end

  // Shadow tags advance every cycle; bubbles zero ID/EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex     <= '0;
      exmem_rd <= '0;
      exmem_rw <= 1'b0;
      exmem_mr <= 1'b0;
      memwb_rd <= '0;
      memwb_rw <= 1'b0;
    end else begin
      if (id_ex_bubble) begin
        idex <= '0;
      end else begin
        idex.rs1 <= bus.id_uses_rs1 ? bus.id_rs1 : '0;
        idex.rs2 <= bus.id_uses_rs2 ? bus.id_rs2 : '0;
        idex.rd        <= bus.id_rd;
        idex.reg_write <= bus.id_reg_write;
        idex.mem_read  <= bus.id_mem_read;
      end
      exmem_rd <= idex.rd;
      exmem_rw <= idex.reg_write;
      exmem_mr <= idex.mem_read;
      memwb_rd <= exmem_rd;
      memwb_rw <= exmem_rw;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (load_use && !bus.ex_branch_taken),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (bus.ex_branch_taken),
    .count (flush_cnt)
  );

  assign bus.pc_write      = pc_write;
  assign bus.if_id_write   = if_id_write;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_bubble  = id_ex_bubble;
  assign bus.forward_a     = fwd_a;
  assign bus.forward_b     = fwd_b;
  assign bus.wb_bypass_rs1 = byp_rs1;
  assign bus.wb_bypass_rs2 = byp_rs2;
  assign bus.stall_count   = stall_cnt;
  assign bus.flush_count   = flush_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl.
// Walks RV32 instruction sequences through the ID stage.
module tb_hazard_forward_ctrl;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int nerr = 0;
  int nchk = 0;

  hazard_forward_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_forward_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in ID.
  task automatic id_in(input int rs1, input int rs2,
                       input int rd, input bit u1,
                       input bit u2, input bit rw,
                       input bit mr, input bit br);
    bus.id_rs1          = 5'(rs1);
    bus.id_rs2          = 5'(rs2);
    bus.id_rd           = 5'(rd);
    bus.id_uses_rs1     = u1;
    bus.id_uses_rs2     = u2;
    bus.id_reg_write    = rw;
    bus.id_mem_read     = mr;
    bus.ex_branch_taken = br;
    #1;
  endtask

  task automatic nop_in();
    id_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lw_x2();
    id_in(0, 0, 2, 1, 0, 1, 1, 0);
  endtask

  task automatic add_x6_x2_x2(input bit br);
    id_in(2, 2, 6, 1, 1, 1, 0, br);
  endtask

  initial begin
    nop_in();
    tick();
    chk("rst_pc_write", 32'(bus.pc_write), 0);
    chk("rst_if_id_write", 32'(bus.if_id_write), 0);
    chk("rst_flush", 32'(bus.if_id_flush), 1);
    chk("rst_bubble", 32'(bus.id_ex_bubble), 1);
    chk("rst_fwd_a", 32'(bus.forward_a), 0);
    tick();
    reset = 1'b0;
    chk("rst_stall_cnt", 32'(bus.stall_count), 0);
    chk("rst_flush_cnt", 32'(bus.flush_count), 0);

    // lw x2,20(x0)
    lw_x2();
    chk("idle_pc_write", 32'(bus.pc_write), 1);
    chk("idle_bubble", 32'(bus.id_ex_bubble), 0);
    tick();
    // addi x3,x0,17
    id_in(0, 0, 3, 1, 0, 1, 0, 0);
    chk("lw_rs1_x0_nostall", 32'(bus.pc_write), 1);
    tick();
    // addi x4,x3,3
    id_in(3, 0, 4, 1, 0, 1, 0, 0);
    tick();
    // addi x5,x3,15 ; addi x4 in EX
    id_in(3, 0, 5, 1, 0, 1, 0, 0);
    chk("exmem_fwd_a", 32'(bus.forward_a), 32'b10);
    chk("exmem_fwd_b", 32'(bus.forward_b), 0);
    chk("exmem_no_stall", 32'(bus.pc_write), 1);
    chk("exmem_no_byp", 32'(bus.wb_bypass_rs1), 0);
    tick();
    nop_in();
    chk("memwb_fwd_a", 32'(bus.forward_a), 32'b01);
    chk("memwb_stall_cnt", 32'(bus.stall_count), 0);
    tick();

    // lw x2 ; add x6,x2,x2 -> load-use
    lw_x2();
    tick();
    add_x6_x2_x2(0);
    chk("lu_pc_write", 32'(bus.pc_write), 0);
    chk("lu_if_id_write", 32'(bus.if_id_write), 0);
    chk("lu_bubble", 32'(bus.id_ex_bubble), 1);
    chk("lu_flush", 32'(bus.if_id_flush), 0);
    tick();
    add_x6_x2_x2(0);
    chk("lu_once_pc_write", 32'(bus.pc_write), 1);
    chk("lu_once_bubble", 32'(bus.id_ex_bubble), 0);
    chk("lu_stall_cnt", 32'(bus.stall_count), 1);
    tick();
    // add x8,x2,x0 in ID ; add x6 in EX ; lw x2 in WB
    id_in(2, 0, 8, 1, 1, 1, 0, 0);
    chk("lu_fwd_a", 32'(bus.forward_a), 32'b01);
    chk("lu_fwd_b", 32'(bus.forward_b), 32'b01);
    chk("byp_rs1", 32'(bus.wb_bypass_rs1), 1);
    chk("byp_rs2_x0", 32'(bus.wb_bypass_rs2), 0);
    tick();

    // addi x0,x0,5 ; addi x7,x0,1
    id_in(0, 0, 0, 1, 0, 1, 0, 0);
    tick();
    id_in(0, 0, 7, 1, 0, 1, 0, 0);
    tick();
    nop_in();
    chk("x0_exmem_fwd_a", 32'(bus.forward_a), 0);
    tick();
    // addi x9,x0,2 with addi x0 in WB
    id_in(0, 0, 9, 1, 0, 1, 0, 0);
    chk("x0_wb_byp", 32'(bus.wb_bypass_rs1), 0);
    chk("x0_memwb_fwd_a", 32'(bus.forward_a), 0);
    tick();

    // branch taken during a load-use
    lw_x2();
    tick();
    add_x6_x2_x2(1);
    chk("br_flush", 32'(bus.if_id_flush), 1);
    chk("br_bubble", 32'(bus.id_ex_bubble), 1);
    chk("br_pc_write", 32'(bus.pc_write), 1);
    chk("br_if_id_write", 32'(bus.if_id_write), 1);
    tick();
    nop_in();
    chk("br_flush_cnt", 32'(bus.flush_count), 1);
    chk("br_stall_cnt", 32'(bus.stall_count), 1);
    tick();

    // reset while a load sits in ID/EX
    lw_x2();
    tick();
    reset = 1'b1;
    add_x6_x2_x2(0);
    chk("mid_rst_pc_write", 32'(bus.pc_write), 0);
    chk("mid_rst_bubble", 32'(bus.id_ex_bubble), 1);
    chk("mid_rst_fwd_b", 32'(bus.forward_b), 0);
    tick();
    reset = 1'b0;
    add_x6_x2_x2(0);
    chk("post_rst_pc_write", 32'(bus.pc_write), 1);
    chk("post_rst_bubble", 32'(bus.id_ex_bubble), 0);
    chk("post_rst_fwd_a", 32'(bus.forward_a), 0);
    chk("post_rst_fwd_b", 32'(bus.forward_b), 0);
    chk("post_rst_stall", 32'(bus.stall_count), 0);
    chk("post_rst_flush", 32'(bus.flush_count), 0);
    tick();

    // 2^CNT_W+3 load-use stalls
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      lw_x2();
      tick();
      add_x6_x2_x2(0);
      chk("sat_stall_event", 32'(bus.pc_write), 0);
      tick();
      nop_in();
      chk("sat_stall_cnt", 32'(bus.stall_count),
          (i + 1 < 15) ? i + 1 : 15);
    end
    chk("sat_final", 32'(bus.stall_count), 15);
    chk("sat_flush_cnt", 32'(bus.flush_count), 0);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
